// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Multi-entry operand register file for the 16-bit datapath.
//               One write port, two registered read ports with write-through
//               bypass, and a one-entry-per-cycle clear sweep.
// Ports       : clk, rst                   - clock, synchronous active-high reset
//               we, waddr, wdata           - write port
//               raddr_a/b -> rdata_a/b     - registered read ports (1-cycle latency)
//               clr                        - start a clear sweep (ignored while sweeping)
//               busy                       - high while the sweep runs
//               wr_drop                    - one-cycle pulse after a refused write
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr,
    output logic             busy,
    output logic             wr_drop
);

    localparam logic [0:0]    c_ST_IDLE  = 1'b0;
    localparam logic [0:0]    c_ST_SWEEP = 1'b1;
    // DEPTH may equal 2^AW, so range checks are done one bit wider.
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);
    localparam bit            c_ZR0      = (ZERO_R0 != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_wr_drop;

    logic             w_sweeping;
    logic             w_sweep_done;
    logic             w_waddr_ok;
    logic             w_wr_ok;
    logic             w_wr_refuse;
    logic [WIDTH-1:0] w_mem_a;
    logic [WIDTH-1:0] w_mem_b;
    logic [WIDTH-1:0] w_rd_a_nxt;
    logic [WIDTH-1:0] w_rd_b_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. clr during a sweep is deliberately not remembered.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (clr)          w_state_nxt = c_ST_SWEEP;
            c_ST_SWEEP: if (w_sweep_done) w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM: outputs / decodes
    always_comb begin
        w_sweeping   = (r_state == c_ST_SWEEP);
        w_sweep_done = w_sweeping && (r_ptr == c_LAST);
        busy         = w_sweeping;
    end

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    always_comb begin
        w_waddr_ok  = ({1'b0, waddr} < c_DEPTH);
        // Entry 0 writes under ZERO_R0 are dropped silently, not refused.
        w_wr_ok     = we && !w_sweeping && w_waddr_ok && !(c_ZR0 && (waddr == '0));
        w_wr_refuse = we && (w_sweeping || !w_waddr_ok);
    end

    // Sweep pointer: held at 0 in IDLE so a new sweep always starts at entry 0.
    always_ff @(posedge clk) begin
        if (rst || !w_sweeping || w_sweep_done) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Storage. A write and a sweep clear never coincide: writes are only
    // accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && (waddr == AW'(i))) begin
                    r_mem[i] <= wdata;
                end else if (w_sweeping && (r_ptr == AW'(i))) begin
                    r_mem[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: array mux, then bypass/zero priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_a = '0;
        w_mem_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) w_mem_a = r_mem[i];
            if (raddr_b == AW'(i)) w_mem_b = r_mem[i];
        end
    end

    always_comb begin
        if ({1'b0, raddr_a} >= c_DEPTH)                w_rd_a_nxt = '0;
        else if (c_ZR0 && (raddr_a == '0))             w_rd_a_nxt = '0;
        else if (w_wr_ok && (waddr == raddr_a))        w_rd_a_nxt = wdata;
        else if (w_sweeping && (r_ptr == raddr_a))     w_rd_a_nxt = '0;
        else                                           w_rd_a_nxt = w_mem_a;

        if ({1'b0, raddr_b} >= c_DEPTH)                w_rd_b_nxt = '0;
        else if (c_ZR0 && (raddr_b == '0))             w_rd_b_nxt = '0;
        else if (w_wr_ok && (waddr == raddr_b))        w_rd_b_nxt = wdata;
        else if (w_sweeping && (r_ptr == raddr_b))     w_rd_b_nxt = '0;
        else                                           w_rd_b_nxt = w_mem_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_rdata_a <= w_rd_a_nxt;
            r_rdata_b <= w_rd_b_nxt;
            r_wr_drop <= w_wr_refuse;
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign wr_drop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. Two instances (ZERO_R0=0
//               and ZERO_R0=1, AW=4, DEPTH=8) share one stimulus stream; a
//               behavioural model checks both every cycle, and directed
//               steps pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int A  = 4;

    logic         clk;
    logic         rst;
    logic         we;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic [A-1:0] raddr_a;
    logic [A-1:0] raddr_b;
    logic         clr;

    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic         busy0, busy1, drop0, drop1;

    int total = 0;
    int bad   = 0;

    reg_file #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_R0(0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra0), .rdata_b(rb0),
        .clr(clr), .busy(busy0), .wr_drop(drop0)
    );

    reg_file #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_R0(1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra1), .rdata_b(rb1),
        .clr(clr), .busy(busy1), .wr_drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 = ZERO_R0 off, index 1 = ZERO_R0 on.
    // ------------------------------------------------------------------
    logic [W-1:0] m_mem [2][D];
    logic [W-1:0] m_ra [2];
    logic [W-1:0] m_rb [2];
    logic         m_busy [2];
    logic         m_drop [2];
    int           m_ptr [2];
    bit           m_valid = 0;

    function automatic logic [W-1:0] m_read(input int d, input int addr, input bit acc);
        if (addr >= D)                        return '0;
        if (d == 1 && addr == 0)              return '0;
        if (acc && int'(waddr) == addr)       return wdata;
        if (m_busy[d] && m_ptr[d] == addr)    return '0;
        return m_mem[d][addr];
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < D; i++) m_mem[d][i] = '0;
                m_ra[d] = '0; m_rb[d] = '0;
                m_busy[d] = 1'b0; m_drop[d] = 1'b0; m_ptr[d] = 0;
            end else begin
                bit acc;
                acc = we && !m_busy[d] && (int'(waddr) < D) && !(d == 1 && waddr == 0);
                m_ra[d] = m_read(d, int'(raddr_a), acc);
                m_rb[d] = m_read(d, int'(raddr_b), acc);
                m_drop[d] = we && (m_busy[d] || int'(waddr) >= D);
                if (acc) m_mem[d][int'(waddr)] = wdata;
                if (m_busy[d]) begin
                    m_mem[d][m_ptr[d]] = '0;
                    if (m_ptr[d] == D - 1) begin
                        m_busy[d] = 1'b0;
                        m_ptr[d]  = 0;
                    end else begin
                        m_ptr[d] = m_ptr[d] + 1;
                    end
                end else if (clr) begin
                    m_busy[d] = 1'b1;
                    m_ptr[d]  = 0;
                end
            end
        end
        if (rst) m_valid = 1;
        #1;
        if (m_valid) begin
            chk("m_rdata_a0", 32'(ra0),   32'(m_ra[0]));
            chk("m_rdata_b0", 32'(rb0),   32'(m_rb[0]));
            chk("m_busy0",    32'(busy0), 32'(m_busy[0]));
            chk("m_drop0",    32'(drop0), 32'(m_drop[0]));
            chk("m_rdata_a1", 32'(ra1),   32'(m_ra[1]));
            chk("m_rdata_b1", 32'(rb1),   32'(m_rb[1]));
            chk("m_busy1",    32'(busy1), 32'(m_busy[1]));
            chk("m_drop1",    32'(drop1), 32'(m_drop[1]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change on the falling edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_drop", 32'(drop0), 0);
        chk("rst_rdata_a", 32'(ra0), 0);

        // Read every entry after reset.
        for (int i = 0; i < D; i++) begin
            raddr_a = A'(i); raddr_b = A'(D - 1 - i);
            step();
            chk("rd_after_rst_a", 32'(ra0), 0);
            chk("rd_after_rst_b", 32'(rb0), 0);
        end

        // Write-through bypass on both ports.
        we = 1'b1; waddr = 4'd3; wdata = 16'h00FE; raddr_a = 4'd3;
        step();
        chk("bypass_a", 32'(ra0), 32'h00FE);
        waddr = 4'd5; wdata = 16'h0FE6; raddr_b = 4'd5;
        step();
        chk("bypass_b", 32'(rb0), 32'h0FE6);
        chk("hold_a",   32'(ra0), 32'h00FE);

        // Fill then sweep, watching entries clear one per edge.
        for (int i = 0; i < D; i++) begin
            waddr = A'(i); wdata = 16'(32'h1111 * (i + 1));
            step();
        end
        we = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sweep_busy_rise", 32'(busy0), 1);
        for (int k = 0; k < D; k++) begin
            raddr_a = A'(k); raddr_b = A'((k + 1) % D);
            step();
            chk("sweep_cleared", 32'(ra0), 0);
            chk("sweep_pending", 32'(rb0), (k < D - 1) ? 32'h1111 * (k + 2) : 0);
            chk("sweep_busy",    32'(busy0), (k < D - 1) ? 1 : 0);
        end

        // Refused writes: during a sweep and out of range.
        clr = 1'b1;
        step();
        clr = 1'b0; we = 1'b1; waddr = 4'd4; wdata = 16'hBEEF;
        step();
        chk("drop_sweep", 32'(drop0), 1);
        we = 1'b0;
        step();
        chk("drop_pulse_end", 32'(drop0), 0);
        for (int i = 0; i < 12 && busy0; i++) step();
        chk("sweep_ended", 32'(busy0), 0);
        we = 1'b1; waddr = 4'd9; raddr_a = 4'd9;
        step();
        chk("drop_range", 32'(drop0), 1);
        chk("rd_range",   32'(ra0), 0);
        step();
        chk("drop_b2b", 32'(drop0), 1);
        we = 1'b0; raddr_a = 4'd4;
        step();
        chk("drop_clear", 32'(drop0), 0);
        chk("no_beef",    32'(ra0), 0);

        // clr and write together, then clr re-pulsed mid-sweep.
        we = 1'b1; waddr = 4'd2; wdata = 16'hAAAA; clr = 1'b1; raddr_a = 4'd2;
        step();
        we = 1'b0; clr = 1'b0;
        chk("clr_wr_bypass", 32'(ra0), 32'hAAAA);
        cnt = busy0 ? 1 : 0;
        for (int i = 0; i < 20 && busy0; i++) begin
            clr = (i == 3);
            step();
            if (busy0) cnt++;
            if (i == 1) chk("clr_wr_landed", 32'(ra0), 32'hAAAA);
            if (i == 2) chk("clr_wr_swept",  32'(ra0), 0);
        end
        clr = 1'b0;
        chk("busy_len", 32'(cnt), 8);

        // Reset in the middle of a sweep.
        we = 1'b1;
        for (int i = 0; i < D; i++) begin
            waddr = A'(i); wdata = 16'(32'h0101 * (i + 3));
            step();
        end
        we = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; raddr_a = 4'd6; raddr_b = 4'd7;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy0), 0);
        step();
        chk("rst_mid_a", 32'(ra0), 0);
        chk("rst_mid_b", 32'(rb0), 0);

        // Entry 0 under ZERO_R0.
        we = 1'b1; waddr = 4'd0; wdata = 16'h1234; raddr_a = 4'd0;
        step();
        we = 1'b0;
        chk("zr0_read",   32'(ra1),   0);
        chk("zr0_nodrop", 32'(drop1), 0);
        chk("r0_normal",  32'(ra0),   32'h1234);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            we      = ($urandom_range(0, 1) == 1);
            waddr   = A'($urandom_range(0, 15));
            wdata   = W'($urandom);
            raddr_a = A'($urandom_range(0, 15));
            raddr_b = A'($urandom_range(0, 15));
            clr     = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0; we = 1'b0; clr = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
